// File: rtl/load_store_unit.sv
// Load/store unit: drives the word-addressed data memory port for
// byte/half/word loads (extract+extend) and stores (read-modify-write).
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWe,
    input  logic [2:0]        reqOp,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqWdata,
    output logic              respValid,
    input  logic              respReady,
    output logic [31:0]       respRdata,
    output logic              respErr,
    output logic [31:0]       memAddr,
    output logic [31:0]       memWriteData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [31:0]       memReadData
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t              state, state_n;
    logic                we_q, we_n;
    logic [2:0]          op_q, op_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [31:0]         wdata_q, wdata_n;

    logic                resp_valid_n;
    logic                resp_err_n;
    logic [31:0]         resp_rdata_n;
    logic [31:0]         mem_addr_n;
    logic [31:0]         mem_wdata_n;
    logic                mem_read_n;
    logic                mem_write_n;

    logic [1:0]          req_size;
    logic                req_illegal;
    logic                req_misal;
    logic                req_err;
    logic [31:0]         word_idx;

    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [31:0]         load_ext;
    logic [31:0]         merged;

    assign reqReady = (state == IDLE) && !rst;

    // Stores only look at the size bits, so 110 is a legal word store.
    assign req_size    = reqOp[1:0];
    assign req_illegal = (req_size == 2'b11) || (!reqWe && reqOp == 3'b110);
    assign req_misal   = ((req_size == 2'b01) && reqAddr[0]) ||
                         ((req_size == 2'b10) && (reqAddr[1:0] != 2'b00));
    assign req_err     = req_illegal || req_misal;
    assign word_idx    = 32'(reqAddr >> 2);

    always_comb begin
        lane_b = 8'h00;
        unique case (addr_q[1:0])
            2'd0: lane_b = memReadData[7:0];
            2'd1: lane_b = memReadData[15:8];
            2'd2: lane_b = memReadData[23:16];
            2'd3: lane_b = memReadData[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = addr_q[1] ? memReadData[31:16] : memReadData[15:0];

        load_ext = memReadData;
        if (op_q[1:0] == 2'b00)
            load_ext = {{24{~op_q[2] & lane_b[7]}}, lane_b};
        else if (op_q[1:0] == 2'b01)
            load_ext = {{16{~op_q[2] & lane_h[15]}}, lane_h};

        merged = memReadData;
        if (op_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_n      = state;
        we_n         = we_q;
        op_n         = op_q;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        resp_valid_n = respValid;
        resp_err_n   = respErr;
        resp_rdata_n = respRdata;
        mem_addr_n   = memAddr;
        mem_wdata_n  = memWriteData;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    we_n         = reqWe;
                    op_n         = reqOp;
                    addr_n       = reqAddr;
                    wdata_n      = reqWdata;
                    resp_rdata_n = 32'h0;
                    if (req_err) begin
                        resp_err_n   = 1'b1;
                        resp_valid_n = 1'b1;
                        state_n      = RESP;
                    end else begin
                        resp_err_n = 1'b0;
                        mem_addr_n = word_idx;
                        if (reqWe && req_size == 2'b10) begin
                            mem_wdata_n = reqWdata;
                            mem_write_n = 1'b1;
                            state_n     = WR;
                        end else begin
                            mem_read_n = 1'b1;
                            state_n    = RD;
                        end
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    mem_wdata_n = merged;
                    mem_write_n = 1'b1;
                    state_n     = WR;
                end else begin
                    resp_rdata_n = load_ext;
                    resp_valid_n = 1'b1;
                    state_n      = RESP;
                end
            end
            WR: begin
                resp_valid_n = 1'b1;
                state_n      = RESP;
            end
            RESP: begin
                if (respReady) begin
                    resp_valid_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            op_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            respValid    <= 1'b0;
            respErr      <= 1'b0;
            respRdata    <= 32'h0;
            memAddr      <= 32'h0;
            memWriteData <= 32'h0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
        end else begin
            state        <= state_n;
            we_q         <= we_n;
            op_q         <= op_n;
            addr_q       <= addr_n;
            wdata_q      <= wdata_n;
            respValid    <= resp_valid_n;
            respErr      <= resp_err_n;
            respRdata    <= resp_rdata_n;
            memAddr      <= mem_addr_n;
            memWriteData <= mem_wdata_n;
            memRead      <= mem_read_n;
            memWrite     <= mem_write_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan steps plus random traffic
// against a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [2:0]  reqOp;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        respValid;
    logic        respReady;
    logic [31:0] respRdata;
    logic        respErr;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [64];
    logic [7:0]  refmem [256];
    bit          init_mem;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .reqValid(reqValid),
        .reqReady(reqReady),
        .reqWe(reqWe),
        .reqOp(reqOp),
        .reqAddr(reqAddr),
        .reqWdata(reqWdata),
        .respValid(respValid),
        .respReady(respReady),
        .respRdata(respRdata),
        .respErr(respErr),
        .memAddr(memAddr),
        .memWriteData(memWriteData),
        .memRead(memRead),
        .memWrite(memWrite),
        .memReadData(memReadData)
    );

    assign memReadData = memRead ? mem[memAddr[5:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (memWrite) begin
            mem[memAddr[5:0]] <= memWriteData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {refmem[b+3], refmem[b+2], refmem[b+1], refmem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op,
                                             input int addr);
        int n;
        longint v;
        n = 1 << op[1:0];
        v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(refmem[addr+i]) << (8 * i);
        if (op[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic do_req(input logic we, input logic [2:0] op,
                          input int addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] rdata_o);
        int n, lat, nrd, nwr, both;
        int exp_lat, exp_rd, exp_wr;
        bit err;
        logic [31:0] exp_rdata, exp_wword, ma, wd;

        n = 1 << op[1:0];
        err = (op[1:0] == 2'b11) || (!we && op == 3'b110) || (addr % n != 0);
        exp_rdata = 32'h0;
        exp_wword = 32'h0;
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            exp_rdata = ref_load(op, addr);
        end else begin
            for (int i = 0; i < n; i++) refmem[addr+i] = wdata[8*i +: 8];
            exp_wword = ref_word(addr);
            exp_lat = (n == 4) ? 2 : 3;
            exp_rd = (n == 4) ? 0 : 1;
            exp_wr = 1;
        end

        @(negedge clk);
        chk("req_ready_idle", 32'(reqReady), 32'd1);
        reqValid = 1'b1;
        reqWe = we;
        reqOp = op;
        reqAddr = 32'(addr);
        reqWdata = wdata;
        respReady = (hold == 0);
        @(posedge clk);
        #1;
        reqValid = 1'b0;

        lat = 0; nrd = 0; nwr = 0; both = 0;
        ma = 32'hx; wd = 32'hx;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (memRead) nrd++;
            if (memWrite) begin nwr++; wd = memWriteData; end
            if (memRead || memWrite) ma = memAddr;
            if (memRead && memWrite) both++;
            if (respValid) lat = k;
            else begin @(posedge clk); #1; end
        end

        chk("latency", 32'(lat), 32'(exp_lat));
        chk("read_cycles", 32'(nrd), 32'(exp_rd));
        chk("write_cycles", 32'(nwr), 32'(exp_wr));
        chk("rd_wr_overlap", 32'(both), 32'd0);
        if (exp_rd + exp_wr > 0) chk("mem_addr", ma, 32'(addr >> 2));
        if (exp_wr > 0) chk("write_word", wd, exp_wword);
        chk("resp_rdata", respRdata, exp_rdata);
        chk("resp_err", 32'(respErr), 32'(err));
        rdata_o = respRdata;

        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(respValid), 32'd1);
            chk("bp_rdata", respRdata, exp_rdata);
            chk("bp_ready", 32'(reqReady), 32'd0);
        end
        respReady = 1'b1;
        @(posedge clk);
        #1;
        chk("post_valid", 32'(respValid), 32'd0);
        chk("post_ready", 32'(reqReady), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int bad, wr_seen, rv_seen;

        rst = 1'b1;
        reqValid = 1'b0;
        reqWe = 1'b0;
        reqOp = 3'b000;
        reqAddr = 32'h0;
        reqWdata = 32'h0;
        respReady = 1'b1;
        init_mem = 1'b1;
        for (int i = 0; i < 256; i++)
            refmem[i] = ((i % 4) == 0) ? 8'(i / 4) : 8'h00;

        repeat (2) @(posedge clk);
        #1;
        init_mem = 1'b0;
        chk("rst_req_ready", 32'(reqReady), 32'd0);
        chk("rst_resp_valid", 32'(respValid), 32'd0);
        chk("rst_resp_err", 32'(respErr), 32'd0);
        chk("rst_resp_rdata", respRdata, 32'h0);
        chk("rst_mem_read", 32'(memRead), 32'd0);
        chk("rst_mem_write", 32'(memWrite), 32'd0);
        chk("rst_mem_addr", memAddr, 32'h0);
        chk("rst_mem_wdata", memWriteData, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(reqReady), 32'd1);

        do_req(1'b0, 3'b010, 'h14, 32'h0, 0, r);
        chk("plan_lw", r, 32'h00000005);
        do_req(1'b1, 3'b000, 'h16, 32'h000000AB, 0, r);
        do_req(1'b0, 3'b000, 'h16, 32'h0, 0, r);
        chk("plan_lb", r, 32'hFFFFFFAB);
        do_req(1'b0, 3'b100, 'h16, 32'h0, 0, r);
        chk("plan_lbu", r, 32'h000000AB);
        do_req(1'b1, 3'b001, 'h1A, 32'h00008001, 0, r);
        do_req(1'b0, 3'b001, 'h1A, 32'h0, 0, r);
        chk("plan_lh", r, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 'h1A, 32'h0, 0, r);
        chk("plan_lhu", r, 32'h00008001);
        do_req(1'b0, 3'b010, 'h18, 32'h0, 0, r);
        chk("plan_word6", r, 32'h80010006);

        do_req(1'b0, 3'b001, 'h13, 32'h0, 0, r);
        do_req(1'b0, 3'b010, 'h16, 32'h0, 0, r);
        do_req(1'b1, 3'b010, 'h01, 32'h12345678, 0, r);
        do_req(1'b0, 3'b011, 'h20, 32'h0, 0, r);
        do_req(1'b0, 3'b110, 'h20, 32'h0, 0, r);
        do_req(1'b1, 3'b110, 'h20, 32'hCAFEF00D, 0, r);

        do_req(1'b0, 3'b010, 'h14, 32'h0, 5, r);
        chk("plan_bp_lw", r, 32'h00AB0005);

        @(negedge clk);
        reqValid = 1'b1;
        reqWe = 1'b1;
        reqOp = 3'b000;
        reqAddr = 32'h21;
        reqWdata = 32'h0000005A;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        chk("abort_in_rd", 32'(memRead), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(reqReady), 32'd1);
        wr_seen = 0;
        rv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (memWrite) wr_seen++;
            if (respValid) rv_seen++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_write", 32'(wr_seen), 32'd0);
        chk("abort_no_resp", 32'(rv_seen), 32'd0);

        for (int t = 0; t < 200; t++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 255)), $urandom,
                   ($urandom_range(0, 7) == 0) ? 2 : 0, r);
        end

        bad = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_word(4 * i)) bad++;
        chk("mem_final", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
